// File: rtl/regfile_mp_bypass.sv
// Multi-port register file: same-cycle write bypass, per-register pending bits, sticky write-conflict flag.
// Latency: writes land 1 edge later; reads, busy and bypass are combinational (0 cycles).
// Backpressure: none; every input is sampled on every rising edge.
module regfile_mp_bypass #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREAD*AW-1:0]     rd_sel,
    output logic [NREAD*WIDTH-1:0]  rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic [NWRITE-1:0]       wr_en,
    input  logic [NWRITE*AW-1:0]    wr_sel,
    input  logic [NWRITE*WIDTH-1:0] wr_data,
    input  logic                    pend_en,
    input  logic [AW-1:0]           pend_sel,
    output logic                    err
);

    logic [WIDTH-1:0] mem      [DEPTH];
    logic [WIDTH-1:0] mem_nxt  [DEPTH];
    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] wr_hit;
    logic [DEPTH-1:0] pend_set;
    logic [NWRITE-1:0] wr_act;
    logic             conflict;
    logic             err_q;

    // A write is live only out of reset and when it does not target the hardwired zero register.
    always_comb begin
        for (int j = 0; j < NWRITE; j++) begin
            wr_act[j] = wr_en[j] && rst_n &&
                        !((ZERO_REG != 0) && (wr_sel[j*AW +: AW] == '0));
        end
    end

    always_comb begin
        conflict = 1'b0;
        for (int j = 0; j < NWRITE; j++) begin
            for (int k = j + 1; k < NWRITE; k++) begin
                if (wr_act[j] && wr_act[k] && (wr_sel[j*AW +: AW] == wr_sel[k*AW +: AW])) begin
                    conflict = 1'b1;
                end
            end
        end
    end

    // Ascending port scan so the highest-numbered matching port lands last and wins.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            mem_nxt[r] = mem[r];
            wr_hit[r]  = 1'b0;
            for (int j = 0; j < NWRITE; j++) begin
                if (wr_act[j] && (wr_sel[j*AW +: AW] == AW'(r))) begin
                    mem_nxt[r] = wr_data[j*WIDTH +: WIDTH];
                    wr_hit[r]  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        pend_set = '0;
        if (pend_en && rst_n && !((ZERO_REG != 0) && (pend_sel == '0))) begin
            pend_set[pend_sel] = 1'b1;
        end
    end

    // Set is ORed after the clear so a new producer issued alongside a retiring write stays outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
            pending <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= mem_nxt[r];
            end
            pending <= (pending & ~wr_hit) | pend_set;
            err_q   <= err_q | conflict;
        end
    end

    assign err = err_q;

    logic [AW-1:0]    rd_idx [NREAD];
    logic [WIDTH-1:0] rd_val [NREAD];
    logic             rd_pnd [NREAD];

    // A forwarded write is the value being waited on, so it also masks the pending bit.
    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            rd_idx[i] = rd_sel[i*AW +: AW];
            rd_val[i] = mem[rd_idx[i]];
            rd_pnd[i] = pending[rd_idx[i]];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWRITE; j++) begin
                    if (wr_act[j] && (wr_sel[j*AW +: AW] == rd_idx[i])) begin
                        rd_val[i] = wr_data[j*WIDTH +: WIDTH];
                        rd_pnd[i] = 1'b0;
                    end
                end
            end
            if (((ZERO_REG != 0) && (rd_idx[i] == '0)) || !rst_n) begin
                rd_val[i] = '0;
                rd_pnd[i] = 1'b0;
            end
            rd_data[i*WIDTH +: WIDTH] = rd_val[i];
            rd_busy[i]                = rd_pnd[i];
        end
    end

endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Directed checks on the default config (bypass on and off) plus a randomised run on a scaled config.
module tb_regfile_mp_bypass;

    logic        clk;
    logic        rst_n;

    logic [9:0]  rd_sel;
    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic [1:0]  wr_en;
    logic [9:0]  wr_sel;
    logic [63:0] wr_data;
    logic        pend_en;
    logic [4:0]  pend_sel;
    logic        err_a, err_b;

    logic [11:0] rd_sel_c;
    logic [63:0] rd_data_c;
    logic [3:0]  rd_busy_c;
    logic [2:0]  wr_en_c;
    logic [8:0]  wr_sel_c;
    logic [47:0] wr_data_c;
    logic        pend_en_c;
    logic [2:0]  pend_sel_c;
    logic        err_c;

    int n_chk  = 0;
    int n_fail = 0;

    regfile_mp_bypass #(.BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_sel(rd_sel), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .pend_en(pend_en),
        .pend_sel(pend_sel), .err(err_a)
    );

    regfile_mp_bypass #(.BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_sel(rd_sel), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .pend_en(pend_en),
        .pend_sel(pend_sel), .err(err_b)
    );

    regfile_mp_bypass #(.WIDTH(16), .DEPTH(8), .NREAD(4), .NWRITE(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .rd_sel(rd_sel_c), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
        .wr_en(wr_en_c), .wr_sel(wr_sel_c), .wr_data(wr_data_c), .pend_en(pend_en_c),
        .pend_sel(pend_sel_c), .err(err_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        wr_en   = '0;
        pend_en = 1'b0;
    endtask

    task automatic wr(input int p, input int r, input logic [31:0] d);
        wr_en[p]            = 1'b1;
        wr_sel[p*5 +: 5]    = 5'(r);
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic rsel(input int p, input int r);
        rd_sel[p*5 +: 5] = 5'(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference state for the scaled instance
    logic [15:0] m_mem [8];
    logic [7:0]  m_pend;
    logic        m_err;
    logic [2:0]  s, sj, sk;
    logic [15:0] ed;
    logic        eb;

    task automatic model_clear();
        for (int r = 0; r < 8; r++) m_mem[r] = '0;
        m_pend = '0;
        m_err  = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        rd_sel = '0; wr_sel = '0; wr_data = '0; pend_sel = '0;
        idle();
        rd_sel_c = '0; wr_en_c = '0; wr_sel_c = '0; wr_data_c = '0;
        pend_en_c = 1'b0; pend_sel_c = '0;

        // Reset state
        #2;
        chk("rst_rd_a", rd_data_a, 64'h0);
        chk("rst_busy_a", rd_busy_a, 2'b00);
        chk("rst_err_a", err_a, 1'b0);
        chk("rst_rd_b", rd_data_b, 64'h0);
        chk("rst_err_c", err_c, 1'b0);
        wr(0, 5, 32'hDEADBEEF);
        rsel(0, 5); rsel(1, 5);
        #1;
        chk("rst_bypass_gated", rd_data_a, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(); idle();
        @(negedge clk);
        chk("r5_a", rd_data_a, 64'hDEADBEEF_DEADBEEF);
        chk("r5_b", rd_data_b, 64'hDEADBEEF_DEADBEEF);

        // Bypass
        tick(); idle();
        wr(0, 7, 32'h12345678); rsel(0, 7); rsel(1, 5);
        @(negedge clk);
        chk("byp_a_rd0", rd_data_a[31:0], 32'h12345678);
        chk("byp_a_rd1", rd_data_a[63:32], 32'hDEADBEEF);
        chk("nobyp_b_rd0", rd_data_b[31:0], 32'h0);
        tick(); idle();
        @(negedge clk);
        chk("nobyp_b_next", rd_data_b[31:0], 32'h12345678);

        // Zero register
        tick();
        wr(0, 0, 32'hFFFFFFFF); wr(1, 0, 32'hFFFFFFFF);
        pend_en = 1'b1; pend_sel = 5'd0; rsel(0, 0);
        @(negedge clk);
        chk("r0_byp_rd", rd_data_a[31:0], 32'h0);
        chk("r0_byp_busy", rd_busy_a[0], 1'b0);
        tick(); idle();
        @(negedge clk);
        chk("r0_rd_a", rd_data_a[31:0], 32'h0);
        chk("r0_rd_b", rd_data_b[31:0], 32'h0);
        chk("r0_busy_a", rd_busy_a[0], 1'b0);
        chk("r0_busy_b", rd_busy_b[0], 1'b0);
        chk("r0_err_a", err_a, 1'b0);
        chk("r0_err_b", err_b, 1'b0);

        // Scoreboard
        tick(); idle();
        pend_en = 1'b1; pend_sel = 5'd9; rsel(0, 9); rsel(1, 9);
        @(negedge clk);
        chk("pend_not_yet", rd_busy_a, 2'b00);
        tick(); idle();
        @(negedge clk);
        chk("pend_set_a", rd_busy_a, 2'b11);
        chk("pend_set_b", rd_busy_b, 2'b11);
        tick();
        wr(1, 9, 32'hAB);
        @(negedge clk);
        chk("pend_byp_busy_a", rd_busy_a, 2'b00);
        chk("pend_byp_rd_a", rd_data_a[31:0], 32'hAB);
        chk("pend_nobyp_busy_b", rd_busy_b, 2'b11);
        chk("pend_nobyp_rd_b", rd_data_b[31:0], 32'h0);
        tick(); idle();
        @(negedge clk);
        chk("pend_clr_a", rd_busy_a, 2'b00);
        chk("pend_clr_b", rd_busy_b, 2'b00);
        chk("pend_clr_rd_b", rd_data_b[31:0], 32'hAB);
        tick();
        pend_en = 1'b1; pend_sel = 5'd9; wr(0, 9, 32'hCD);
        @(negedge clk);
        chk("setclr_byp_busy", rd_busy_a, 2'b00);
        chk("setclr_byp_rd", rd_data_a[31:0], 32'hCD);
        tick(); idle();
        @(negedge clk);
        chk("setclr_busy_a", rd_busy_a, 2'b11);
        chk("setclr_busy_b", rd_busy_b, 2'b11);
        chk("setclr_rd_a", rd_data_a[31:0], 32'hCD);

        // Write conflict
        tick();
        wr(0, 3, 32'h1111); wr(1, 3, 32'h2222); rsel(0, 3); rsel(1, 9);
        @(negedge clk);
        chk("conf_byp_rd", rd_data_a[31:0], 32'h2222);
        chk("conf_err_early", err_a, 1'b0);
        tick(); idle();
        @(negedge clk);
        chk("conf_rd_a", rd_data_a[31:0], 32'h2222);
        chk("conf_rd_b", rd_data_b[31:0], 32'h2222);
        chk("conf_err_a", err_a, 1'b1);
        chk("conf_err_b", err_b, 1'b1);
        tick();
        @(negedge clk);
        chk("conf_err_sticky", err_a, 1'b1);

        // Asynchronous reset mid-operation, with writes held off while low
        #1 rst_n = 1'b0;
        #1;
        chk("arst_err_a", err_a, 1'b0);
        chk("arst_rd_a", rd_data_a, 64'h0);
        chk("arst_busy_a", rd_busy_a, 2'b00);
        wr(0, 3, 32'h5555);
        @(posedge clk);
        #1 idle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_r3_a", rd_data_a[31:0], 32'h0);
        chk("arst_r3_b", rd_data_b[31:0], 32'h0);
        chk("arst_r9_busy", rd_busy_a[1], 1'b0);
        chk("arst_err_b", err_b, 1'b0);

        // Scaled configuration against a reference model
        model_clear();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(posedge clk);
            #1;
            wr_en_c    = 3'($urandom);
            wr_sel_c   = 9'($urandom);
            wr_data_c  = {16'($urandom), 16'($urandom), 16'($urandom)};
            rd_sel_c   = 12'($urandom);
            pend_en_c  = 1'($urandom);
            pend_sel_c = 3'($urandom);
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                s  = rd_sel_c[i*3 +: 3];
                ed = m_mem[s];
                eb = m_pend[s];
                for (int j = 0; j < 3; j++) begin
                    if (wr_en_c[j] && (wr_sel_c[j*3 +: 3] == s)) begin
                        ed = wr_data_c[j*16 +: 16];
                        eb = 1'b0;
                    end
                end
                if (s == 3'd0) begin
                    ed = '0;
                    eb = 1'b0;
                end
                chk($sformatf("c_rd%0d_cyc%0d", i, cyc), rd_data_c[i*16 +: 16], ed);
                chk($sformatf("c_busy%0d_cyc%0d", i, cyc), rd_busy_c[i], eb);
            end
            chk($sformatf("c_err_cyc%0d", cyc), err_c, m_err);
            if (cyc % 37 == 36) begin
                #1 rst_n = 1'b0;
                #1;
                chk($sformatf("c_arst_err_cyc%0d", cyc), err_c, 1'b0);
                rst_n = 1'b1;
                model_clear();
            end
            for (int j = 0; j < 3; j++) begin
                for (int k = j + 1; k < 3; k++) begin
                    sj = wr_sel_c[j*3 +: 3];
                    sk = wr_sel_c[k*3 +: 3];
                    if (wr_en_c[j] && wr_en_c[k] && (sj == sk) && (sj != 3'd0)) m_err = 1'b1;
                end
            end
            for (int j = 0; j < 3; j++) begin
                sj = wr_sel_c[j*3 +: 3];
                if (wr_en_c[j] && (sj != 3'd0)) begin
                    m_mem[sj]  = wr_data_c[j*16 +: 16];
                    m_pend[sj] = 1'b0;
                end
            end
            if (pend_en_c && (pend_sel_c != 3'd0)) m_pend[pend_sel_c] = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp_bypass.md
# regfile_mp_bypass

Parametrised multi-port register file with write-to-read bypass, per-register pending (scoreboard) bits and a sticky write-conflict error flag. It is the next-generation register file for the decode stage. Read ports feed operand fetch. Write ports take retirement results from several pipelines. Pending bits let issue logic stall on load-use and long-latency hazards without a separate scoreboard.

## Interface
Parameters:
- WIDTH, 32, data width of each register
- DEPTH, 32, number of registers (power of two, ≥2)
- NREAD, 2, number of read ports
- NWRITE, 2, number of write ports
- ZERO_REG, 1, when 1, register 0 always reads 0 and ignores writes and pending sets
- BYPASS, 1, when 1, same-cycle writes are forwarded to reads
- AW (derived), $clog2(DEPTH)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_sel  in  NREAD*AW  read register index; port i uses bits [i*AW +: AW]
- rd_data  out  NREAD*WIDTH  read data per port, combinational
- rd_busy  out  NREAD  pending bit of the selected register, combinational, bypass-aware
- wr_en  in  NWRITE  write enable per port
- wr_sel  in  NWRITE*AW  write register index per port
- wr_data  in  NWRITE*WIDTH  write data per port
- pend_en  in  1  mark register pend_sel as pending (issue of a new producer)
- pend_sel  in  AW  register to mark pending
- err  out  1  sticky flag: two enabled write ports targeted the same register in one cycle

## Operation
- Storage: DEPTH×WIDTH flops and a DEPTH-bit pending vector.
- Write: on each rising edge, every register whose index matches an enabled write port is loaded with that port's data.
  - If several enabled ports hit the same index, the highest-numbered port wins.
  - The same condition sets err. err stays set until reset.
- Read: rd_data[i] = mem[rd_sel[i]], unless bypass applies.
  - With BYPASS=1, if any enabled write port targets rd_sel[i] in the same cycle, rd_data[i] returns that write data. Highest-numbered matching port wins.
- ZERO_REG=1:
  - rd_data for index 0 is always 0, including under bypass.
  - Writes to index 0 are dropped and do not set err.
  - pend_en with pend_sel=0 is ignored.
  - rd_busy for index 0 is always 0.
- Pending bits:
  - pend_en sets pending[pend_sel] at the clock edge.
  - Any enabled write to a register clears its pending bit.
  - Set and clear of the same register in one cycle: the set wins, because the newer producer is outstanding.
- rd_busy[i] = pending[rd_sel[i]], except it reads 0 when BYPASS=1 and a write to rd_sel[i] is present in the same cycle. The value being forwarded is the one being waited on.
- With BYPASS=0, reads and rd_busy reflect only registered state.

## Timing
- Reset (rst_n low, asynchronous): all registers 0, all pending bits 0, err 0.
  - rd_data reads 0 and rd_busy reads 0 while in reset.
  - Writes and pend_en are ignored while rst_n is low.
  - Reset asserted mid-operation discards all state immediately.
- Write latency: 1 edge to the array. Bypass latency is 0 cycles (combinational).
- Pending-bit set or clear is visible on rd_busy in the cycle after the edge.
- err asserts in the cycle after the offending edge.
- No handshakes. All inputs are sampled on every rising edge; reads are purely combinational from state and the current write inputs.

## Test plan
- Reset then read: assert rst_n=0 → rd_data=0 and rd_busy=0 on all ports. Write r5=0xDEADBEEF, release reset, read r5 → 0xDEADBEEF on both read ports the next cycle.
- Bypass: in one cycle, wr_en[0]=1, wr_sel=7, wr_data=0x12345678, rd_sel[0]=7 → rd_data[0]=0x12345678 the same cycle. Repeat with BYPASS=0 → old value 0, then 0x12345678 the next cycle.
- Write conflict: ports 0 and 1 both write r3, with 0x1111 and 0x2222 → r3 reads 0x2222. err=1 from the next cycle and stays 1 until rst_n pulses low.
- Zero register: write r0=0xFFFFFFFF and pend_en with pend_sel=0 → r0 reads 0, rd_busy=0, err stays 0. A simultaneous two-port write to r0 also leaves err=0.
- Scoreboard:
  - pend_en on r9 → rd_busy=1 for r9 the next cycle.
  - Write r9=0xAB with rd_sel=9 → rd_busy=0 and rd_data=0xAB the same cycle. Pending is cleared from the next cycle.
  - pend_en and write on r9 in the same cycle → rd_busy=1 afterwards.
- Scaling: DEPTH=8, NREAD=4, NWRITE=3, WIDTH=16. Random writes compared against a reference model for 10k cycles → all reads, busy bits and err match.
